pcm_sample_fifo: RTL
====================

# pcm_sample_fifo

Elastic buffer between the PDM capture/decimation chain and the host-side readout logic (SPI/UART bridge). It detects each new PCM sample from the capture stage's level-style `ready` output and stores the sample in a first-word-fall-through FIFO. It presents the samples on a valid/ready stream and reports fill level, a watermark flag and overflow status, so the readout side can drain in bursts without losing audio.

## Interface
- `DATA_WIDTH`, 16: PCM sample width.
- `DEPTH`, 256: FIFO entries; power of two, at least 4.
- `WATERMARK`, 128: `wm_flag` asserts when `level >= WATERMARK`; range 1..DEPTH.

Ports:
- `clk`  in  1: system clock. This is the only clock in the block.
- `rst`  in  1: reset. Synchronous to `clk`, active-high.
- `in_data`  in  DATA_WIDTH: PCM sample from the capture stage.
- `in_ready`  in  1: capture-stage sample flag. This is a level, not a one-cycle pulse, and it can stay high for many `clk` cycles.
- `out_data`  out  DATA_WIDTH: head-of-FIFO sample.
- `out_valid`  out  1: FIFO is not empty.
- `out_ready`  in  1: consumer accepts `out_data`.
- `flush`  in  1: synchronous clear of the FIFO contents and status.
- `level`  out  $clog2(DEPTH)+1: number of stored samples.
- `wm_flag`  out  1: level is at or above WATERMARK.
- `ovf`  out  1: sticky overflow flag.
- `ovf_count`  out  16: overflow counter. This port exists only when `PCM_FIFO_OVF_COUNT_EN` is defined.

## Operation
- Sample detect:
  - Register `in_ready` into `rdy_q`.
  - A push request `push` occurs on any cycle where `rdy_q==1 && in_ready==0` (falling edge).
  - `in_data` is sampled in that same cycle. Upstream data is stable once its ready level drops.
  - Exactly one push occurs per high period of `in_ready`, whatever its length.
- Pop: `pop = out_valid && out_ready`.
- Write pointer, read pointer and level:
  - Read and write pointers are each `$clog2(DEPTH)` bits and wrap modulo DEPTH.
  - `level` is updated by +1, −1 or 0 according to the accepted push and pop.
- Full (`level==DEPTH`) with push and no pop:
  - The sample is dropped (newest data is discarded).
  - `ovf` is set.
  - Pointers and level do not change.
- Full with push and pop in the same cycle: both are accepted and `level` stays at DEPTH. This is not an overflow.
- Empty with push and pop in the same cycle: impossible, because `out_valid==0` when empty.
- Empty with only a pop request: ignored, since `out_valid` is 0.
- `flush`:
  - Clears both pointers, `level` and `ovf` (and `ovf_count`).
  - Any push or pop in the same cycle is discarded.
  - `rdy_q` is not cleared, so a falling edge that coincides with the flush cycle is lost.
- `out_data` reads the entry at the read pointer. Its value is only meaningful while `out_valid==1`.
- `wm_flag` and `out_valid` are registered. Both are derived from the next-state level.

## Timing
- Reset values:
  - `out_valid=0`, `level=0`, `wm_flag=0`, `ovf=0`, `ovf_count=0`.
  - `rdy_q=0`.
  - `out_data` is 0 or undefined; it is don't-care while `out_valid==0`.
- Latency: a falling edge of `in_ready` is seen in cycle N, the sample is written at the end of N, and `out_valid`/`out_data` show it in cycle N+1.
- Pop latency: a pop accepted in cycle N presents the next entry (or `out_valid=0`) in cycle N+1.
- Throughput:
  - One pop per cycle.
  - Pushes are limited by the upstream sample rate. The minimum push spacing is 2 cycles (high for one cycle, then low).
- Stream rule: `out_data` must hold steady while `out_valid && !out_ready`.
- Reset during operation: a synchronous `rst` takes priority over `flush`, push and pop, and restores all reset values the next cycle.

## Configuration
- `PCM_FIFO_OVF_COUNT_EN` defined:
  - Adds the `ovf_count` port, a 16-bit counter.
  - The counter increments on every dropped sample and saturates at 0xFFFF.
  - It is cleared by `rst` or `flush`.
- Not defined:
  - The port and the counter are absent.
  - `ovf` is the only overflow indication.

## Structure
- Package `pcm_fifo_pkg` holds:
  - A pointer-width helper function.
  - The `pcm_sample_t` typedef (`logic signed [DATA_WIDTH-1:0]`, with the width as a package constant of 16).
  - The `OVF_CNT_MAX` constant.
- Sub-module `pcm_fifo_ram`:
  - Simple dual-port storage with a synchronous write port and an asynchronous read port, sized DEPTH x DATA_WIDTH.
  - It infers distributed RAM, which keeps the first-word-fall-through timing exact.
- The top level holds the edge detector, pointers, level and status logic.

## Test plan
- Reset, then hold `in_ready` high for 33 cycles with `in_data=0x1234` before dropping it.
  - Exactly one entry is pushed.
  - `out_valid` rises on the cycle after the drop, with `out_data=0x1234` and `level=1`.
- Push 0x0001..0x0005 with `out_ready=0`, then assert `out_ready`.
  - Output is 1,2,3,4,5 on consecutive cycles, then `out_valid=0` and `level=0`.
- With DEPTH=8 and WATERMARK=6, push 9 samples without popping.
  - `wm_flag` rises after the 6th push.
  - `level` reaches 8, the 9th sample is dropped and `ovf=1`.
  - With the macro defined, `ovf_count=1`.
  - Draining the FIFO returns the first 8 samples.
- Fill DEPTH=8, then hold `out_ready=1` while a push lands in the same cycle as a pop.
  - `level` stays at 8, `ovf` stays 0, and the pushed sample appears last.
- Assert `flush` with `level=5` and `ovf=1`, in the same cycle as a falling edge of `in_ready`.
  - Next cycle: `level=0`, `out_valid=0`, `ovf=0`, and the coincident sample is not stored.
- Push 2·DEPTH+3 samples while popping steadily.
  - Output order matches input across pointer wrap, with no loss and `ovf=0`.

Source files
------------

// File: rtl/pcm_fifo_pkg.sv
// pcm_fifo_pkg
// Shared definitions for the PCM sample FIFO:
//   ptr_width()  - pointer width for a power-of-two FIFO depth
//   PCM_WIDTH    - native PCM sample width
//   pcm_sample_t - signed PCM sample type
//   OVF_CNT_MAX  - saturation value of the optional overflow counter
//                  (the counter exists when PCM_FIFO_OVF_COUNT_EN is defined)
package pcm_fifo_pkg;

    localparam int PCM_WIDTH = 16;

    typedef logic signed [PCM_WIDTH-1:0] pcm_sample_t;

    localparam logic [15:0] OVF_CNT_MAX = 16'hFFFF;

    // Pointer width needed to index a FIFO of the given depth (at least 1 bit).
    function automatic int ptr_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pcm_fifo_ram.sv
// pcm_fifo_ram
// Simple dual-port storage, DEPTH x DATA_WIDTH.
// Synchronous write port, asynchronous read port, so the head entry is
// visible in the same cycle the read pointer points at it (FWFT timing).
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address
//   rd_data  out  combinational read data
module pcm_fifo_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 256,
    parameter int AW         = 8
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pcm_sample_fifo.sv
// pcm_sample_fifo
// Elastic buffer between the PDM capture/decimation chain and the host
// readout. A new sample is detected on the falling edge of the capture
// stage's level-style ready flag and written into a first-word-fall-through
// FIFO, which is drained over a valid/ready stream.
//
// Optional feature: define PCM_FIFO_OVF_COUNT_EN to add the 16-bit
// saturating ovf_count port.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   in_data    in   PCM sample from capture stage
//   in_ready   in   capture-stage sample flag (level)
//   out_data   out  head-of-FIFO sample
//   out_valid  out  FIFO not empty (registered)
//   out_ready  in   consumer accepts out_data
//   flush      in   synchronous clear of contents and status
//   level      out  number of stored samples
//   wm_flag    out  level >= WATERMARK (registered)
//   ovf        out  sticky overflow flag
//   ovf_count  out  saturating drop counter (PCM_FIFO_OVF_COUNT_EN only)
//
// Stream handshake: a beat transfers on every cycle where out_valid and
// out_ready are both high; while out_valid is high and out_ready is low,
// out_data holds steady; out_valid never depends on out_ready.
module pcm_sample_fifo
    import pcm_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 256,
    parameter int WATERMARK  = 128
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic                        in_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    input  logic                        flush,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        wm_flag,
    output logic                        ovf
`ifdef PCM_FIFO_OVF_COUNT_EN
    ,
    output logic [15:0]                 ovf_count
`endif
);

    localparam int AW = ptr_width(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          rdy_q;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_nxt;
    logic          push;
    logic          pop;
    logic          full;
    logic          wr_en;
    logic          rd_en;
    logic          drop;

    // One push per high period of in_ready: its falling edge.
    assign push = rdy_q & ~in_ready;
    assign pop  = out_valid & out_ready;
    assign full = (level == LW'(DEPTH));

    // When full, a simultaneous pop frees the slot the push needs.
    assign wr_en = push & (~full | pop) & ~flush;
    assign rd_en = pop & ~flush;
    assign drop  = push & full & ~pop & ~flush;

    always_comb begin
        level_nxt = level;
        if (flush) begin
            level_nxt = '0;
        end else begin
            case ({wr_en, rd_en})
                2'b10:   level_nxt = level + LW'(1);
                2'b01:   level_nxt = level - LW'(1);
                default: level_nxt = level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q     <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            wm_flag   <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            // rdy_q keeps tracking through a flush, so an edge in that
            // cycle is consumed and lost rather than replayed.
            rdy_q     <= in_ready;
            level     <= level_nxt;
            out_valid <= (level_nxt != '0);
            wm_flag   <= (level_nxt >= LW'(WATERMARK));
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                ovf    <= 1'b0;
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + AW'(1);
                if (rd_en) rd_ptr <= rd_ptr + AW'(1);
                if (drop)  ovf    <= 1'b1;
            end
        end
    end

`ifdef PCM_FIFO_OVF_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ovf_count <= '0;
        end else if (drop && (ovf_count != OVF_CNT_MAX)) begin
            ovf_count <= ovf_count + 16'd1;
        end
    end
`endif

    pcm_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (in_data),
        .rd_addr (rd_ptr),
        .rd_data (out_data)
    );

endmodule
